// File: rtl/aes_loader_pkg.sv
// Shared types and constants for the AES block loader.
package aes_loader_pkg;
  localparam int BLOCK_W            = 128;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {LOAD, HOLD, ISSUE, WAIT} state_e;
endpackage

// File: rtl/aes_word_shifter.sv
// Big-endian word assembler: shifts WORD_W words into a 128-bit block and
// pulses done_o on the completing word, with blk_o already holding the full block.
module aes_word_shifter
  import aes_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [WORD_W-1:0]  data_i,
  output logic [BLOCK_W-1:0] blk_o,
  output logic               done_o
);
  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int CW    = $clog2(WORDS);

  // Only the first WORDS-1 words need storage; the last one arrives live.
  logic [BLOCK_W-WORD_W-1:0] buf_q, buf_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  assign blk_o  = {buf_q, data_i};
  assign done_o = push_i && (cnt_q == CW'(WORDS - 1));

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (push_i) begin
      buf_d = blk_o[BLOCK_W-WORD_W-1:0];
      cnt_d = done_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/aes_block_loader.sv
// Assembles key/plaintext blocks from a word stream and issues them to the AES core.
// Optional WAIT watchdog with sticky err: define AES_LOADER_TIMEOUT_EN.
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  input  logic               s_is_key,
  output logic               s_ready,
  output logic [BLOCK_W-1:0] aes_plain_text,
  output logic [BLOCK_W-1:0] aes_key,
  output logic               aes_input_valid,
  input  logic               aes_output_valid,
  output logic               key_valid,
  output logic               busy,
  output logic               err
);
  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] key_q, text_q, key_blk, text_blk;
  logic               kv_q, key_done, text_done, key_push, text_push, tmo_fire;

  assign key_push  = s_valid && s_ready && s_is_key;
  assign text_push = s_valid && s_ready && !s_is_key;

  aes_word_shifter #(.WORD_W(WORD_W)) u_key (
    .clk(clk), .rst(rst), .push_i(key_push), .data_i(s_data),
    .blk_o(key_blk), .done_o(key_done)
  );

  aes_word_shifter #(.WORD_W(WORD_W)) u_text (
    .clk(clk), .rst(rst), .push_i(text_push), .data_i(s_data),
    .blk_o(text_blk), .done_o(text_done)
  );

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q;
  logic          err_q;

  assign tmo_fire = (state_q == WAIT) && !aes_output_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == WAIT) ? tmo_q + 1'b1 : '0;
      if (tmo_fire) err_q <= 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      key_q   <= '0;
      text_q  <= '0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (key_done) begin
        key_q <= key_blk;
        kv_q  <= 1'b1;
      end
      if (text_done) text_q <= text_blk;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (text_done) state_d = (kv_q || key_done) ? ISSUE : HOLD;
      HOLD:    if (key_done) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (aes_output_valid || tmo_fire) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // s_ready is gated by rst so every output reads 0 while reset is held.
  always_comb begin
    s_ready         = rst && ((state_q == LOAD) || ((state_q == HOLD) && s_is_key));
    aes_input_valid = (state_q == ISSUE);
    busy            = (state_q == ISSUE) || (state_q == WAIT);
  end

  assign aes_key        = key_q;
  assign aes_plain_text = text_q;
  assign key_valid      = kv_q;
endmodule

// File: tb/tb_aes_block_loader.sv
// Randomized + directed bench for aes_block_loader against a queue-based model.
module tb_aes_block_loader;
  localparam int W     = 32;
  localparam int WORDS = 128 / W;
  localparam int TMO   = 16;

  logic         clk, rst, s_valid, s_is_key, s_ready, aes_input_valid;
  logic         aes_output_valid, key_valid, busy, err;
  logic [W-1:0] s_data;
  logic [127:0] aes_plain_text, aes_key;

  aes_block_loader #(.WORD_W(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_is_key(s_is_key),
    .s_ready(s_ready), .aes_plain_text(aes_plain_text), .aes_key(aes_key),
    .aes_input_valid(aes_input_valid), .aes_output_valid(aes_output_valid),
    .key_valid(key_valid), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: phase 0=loading 1=holding for key 2=issuing 3=waiting on core
  int           ph, wcnt;
  logic [W-1:0] kq[$], tq[$];
  logic [127:0] mkey, mtext;
  bit           mkv, merr;

  function automatic logic [127:0] pack(input logic [W-1:0] q[$]);
    logic [127:0] b = '0;
    foreach (q[i]) b = {b[127-W:0], q[i]};
    return b;
  endfunction

  task automatic model_reset();
    ph = 0; wcnt = 0; kq.delete(); tq.delete();
    mkey = '0; mtext = '0; mkv = 0; merr = 0;
  endtask

  task automatic step(input bit v, input bit k, input logic [W-1:0] d, input bit aov);
    bit rdy, acc, kd, td;
    @(negedge clk);
    s_valid = v; s_is_key = k; s_data = d; aes_output_valid = aov;
    #1;
    rdy = (ph == 0) || (ph == 1 && k);
    chk("s_ready", 128'(s_ready), 128'(rdy));
    chk("input_valid", 128'(aes_input_valid), 128'(ph == 2));
    chk("busy", 128'(busy), 128'(ph >= 2));
    chk("key_valid", 128'(key_valid), 128'(mkv));
    chk("err", 128'(err), 128'(merr));
    chk("aes_key", aes_key, mkey);
    chk("aes_plain_text", aes_plain_text, mtext);
    acc = v && rdy; kd = 0; td = 0;
    if (acc && k) begin
      kq.push_back(d);
      if (kq.size() == WORDS) begin mkey = pack(kq); kq.delete(); kd = 1; end
    end
    if (acc && !k) begin
      tq.push_back(d);
      if (tq.size() == WORDS) begin mtext = pack(tq); tq.delete(); td = 1; end
    end
    case (ph)
      0: if (td) ph = (mkv || kd) ? 2 : 1;
      1: if (kd) ph = 2;
      2: begin ph = 3; wcnt = 0; end
      default: if (aov) ph = 0;
`ifdef AES_LOADER_TIMEOUT_EN
               else begin
                 wcnt++;
                 if (wcnt == TMO) begin ph = 0; merr = 1; end
               end
`endif
    endcase
    if (kd) mkv = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 0; s_is_key = 0; s_data = '0; aes_output_valid = 0; rst = 0;
    #1;
    chk("rst_s_ready", 128'(s_ready), 128'(0));
    chk("rst_input_valid", 128'(aes_input_valid), 128'(0));
    chk("rst_key_valid", 128'(key_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_key", aes_key, 128'(0));
    chk("rst_text", aes_plain_text, 128'(0));
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  logic [W-1:0] fk[WORDS] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
  logic [W-1:0] ft[WORDS] = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};

  initial begin
    rst = 0; s_valid = 0; s_is_key = 0; s_data = '0; aes_output_valid = 0;
    model_reset();
    do_reset();

    // FIPS-197 vector
    for (int i = 0; i < WORDS; i++) step(1, 1, fk[i], 0);
    for (int i = 0; i < WORDS; i++) step(1, 0, ft[i], 0);
    step(0, 0, '0, 0);
    chk("fips_iv", 128'(aes_input_valid), 128'(1));
    chk("fips_pt", aes_plain_text, 128'h3243f6a8885a308d313198a2e0370734);
    chk("fips_key", aes_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    // Backpressure in WAIT, then release
    for (int i = 0; i < 3; i++) step(1, i[0], $urandom, 0);
    step(1, 0, $urandom, 1);
    step(1, 0, 32'h11111111, 0);
    chk("after_wait_ready", 128'(s_ready), 128'(1));

    // Partial key reload: two words leave key untouched, two more replace it
    do_reset();
    for (int i = 0; i < WORDS; i++) step(1, 1, fk[i], 0);
    step(1, 1, 32'hdeadbeef, 0);
    step(1, 1, 32'hcafef00d, 0);
    step(0, 0, '0, 0);
    chk("partial_key", aes_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    step(1, 1, 32'h01234567, 0);
    step(1, 1, 32'h89abcdef, 0);
    step(0, 0, '0, 0);
    chk("reload_key", aes_key, 128'hdeadbeefcafef00d0123456789abcdef);

    // Text first with no key: HOLD refuses text, accepts key
    do_reset();
    for (int i = 0; i < WORDS; i++) step(1, 0, ft[i], 0);
    step(1, 0, $urandom, 0);
    chk("hold_text_ready", 128'(s_ready), 128'(0));
    for (int i = 0; i < WORDS; i++) step(1, 1, fk[i], 0);
    step(0, 0, '0, 0);
    chk("hold_issue", 128'(aes_input_valid), 128'(1));
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0);

    // Reset while in WAIT forgets the key
    do_reset();
    chk("post_rst_kv", 128'(key_valid), 128'(0));
    for (int i = 0; i < WORDS; i++) step(1, 0, $urandom, 0);
    step(0, 0, '0, 0);

`ifdef AES_LOADER_TIMEOUT_EN
    for (int i = 0; i < WORDS; i++) step(1, 1, $urandom, 0);
    for (int i = 0; i < TMO + 3; i++) step(0, 0, '0, 0);
    chk("tmo_err", 128'(err), 128'(1));
    chk("tmo_ready", 128'(s_ready), 128'(1));
`endif

    // Random interleaving, spurious aes_output_valid, occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 9) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
